// File: rtl/imm_encode_gen_if.sv
// Request and instruction-word handshake bundle for imm_encode_gen.
// The master drives requests and consumes words; the slave is the encoder.
interface imm_encode_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_fmt;
  logic        req_li;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_last;
  logic        inst_err;

  modport master (
    output req_valid, req_fmt, req_li,
    output req_opcode, req_funct3,
    output req_rd, req_rs1, req_rs2,
    output req_imm, inst_ready,
    input  req_ready, inst_valid,
    input  inst, inst_last, inst_err
  );

  modport slave (
    input  req_valid, req_fmt, req_li,
    input  req_opcode, req_funct3,
    input  req_rd, req_rs1, req_rs2,
    input  req_imm, inst_ready,
    output req_ready, inst_valid,
    output inst, inst_last, inst_err
  );
endinterface

// File: rtl/imm_encode_gen.sv
// RV32I instruction encoder with LI (LUI/ADDI) expansion.
// Define IMMENC_STATS_EN to add handshake/error counters.
module imm_encode_gen #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic clk,
  input  logic rst,
  imm_encode_gen_if.slave bus
`ifdef IMMENC_STATS_EN
  ,
  output logic [31:0] stat_inst_cnt,
  output logic [15:0] stat_err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    EMIT2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] inst_q, word2_q;
  logic        last_q, err_q;

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        ok11, ok12, ok20;
  logic [19:0] hi;
  logic [31:0] lui_w;

  logic [4:0]  fmt_sel;
  logic [31:0] enc_word, enc_word2;
  logic        enc_last, enc_err;

  logic        hs, accept;

  assign imm = bus.req_imm;
  assign rd  = bus.req_rd;
  assign rs1 = bus.req_rs1;
  assign rs2 = bus.req_rs2;
  assign opc = bus.req_opcode;
  assign f3  = bus.req_funct3;

  assign ok11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign ok12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign ok20 = (&imm[31:20]) | ~(|imm[31:20]);

  // Rounded upper part so that ADDI's sign-extended lo lands on imm.
  assign hi    = imm[31:12] + {19'd0, imm[11]};
  assign lui_w = {hi, rd, 7'h37};

  always_comb begin
    enc_word  = NOP_WORD;
    enc_word2 = '0;
    enc_last  = 1'b1;
    enc_err   = 1'b0;
    fmt_sel   = $onehot(bus.req_fmt) ? bus.req_fmt : 5'd0;
    if (bus.req_li) begin
      if (ok11) begin
        enc_word = {imm[11:0], 5'd0, 3'd0, rd, 7'h13};
      end else if (imm[11:0] == 12'd0) begin
        enc_word = lui_w;
      end else begin
        enc_word  = lui_w;
        enc_word2 = {imm[11:0], rd, 3'd0, rd, 7'h13};
        enc_last  = 1'b0;
      end
    end else begin
      unique case (1'b1)
        fmt_sel[0]: begin
          enc_word = {imm[31:12], rd, opc};
          enc_err  = |imm[11:0];
        end
        fmt_sel[1]: begin
          enc_word = {imm[20], imm[10:1], imm[11],
                      imm[19:12], rd, opc};
          enc_err  = ~ok20 | imm[0];
        end
        fmt_sel[2]: begin
          enc_word = {imm[11:0], rs1, f3, rd, opc};
          enc_err  = ~ok11;
        end
        fmt_sel[3]: begin
          enc_word = {imm[12], imm[10:5], rs2, rs1,
                      f3, imm[4:1], imm[11], opc};
          enc_err  = ~ok12 | imm[0];
        end
        fmt_sel[4]: begin
          enc_word = {imm[11:5], rs2, rs1, f3,
                      imm[4:0], opc};
          enc_err  = ~ok11;
        end
        default: begin
          enc_word = NOP_WORD;
          enc_err  = 1'b1;
        end
      endcase
    end
  end

  assign bus.inst_valid = (state_q != IDLE);
  assign bus.inst       = inst_q;
  assign bus.inst_last  = last_q;
  assign bus.inst_err   = err_q;

  assign hs = bus.inst_valid && bus.inst_ready;
  assign bus.req_ready = rst &&
    ((state_q == IDLE) || (hs && last_q));
  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EMIT;
      EMIT: begin
        if (hs) begin
          if (!last_q)     state_d = EMIT2;
          else if (accept) state_d = EMIT;
          else             state_d = IDLE;
        end
      end
      EMIT2: begin
        if (hs) state_d = accept ? EMIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      inst_q  <= '0;
      word2_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        inst_q  <= enc_word;
        word2_q <= enc_word2;
        last_q  <= enc_last;
        err_q   <= enc_err;
      end else if (state_q == EMIT && hs && !last_q) begin
        inst_q <= word2_q;
        last_q <= 1'b1;
        err_q  <= 1'b0;
      end
    end
  end

`ifdef IMMENC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_inst_cnt <= '0;
      stat_err_cnt  <= '0;
    end else if (hs) begin
      stat_inst_cnt <= stat_inst_cnt + 32'd1;
      if (err_q && stat_err_cnt != 16'hFFFF)
        stat_err_cnt <= stat_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_encode_gen.sv
// Self-checking bench for imm_encode_gen: directed vectors plus
// randomized requests against an arithmetic reference model.
module tb_imm_encode_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_encode_gen_if bus();

`ifdef IMMENC_STATS_EN
  logic [31:0] stat_inst_cnt;
  logic [15:0] stat_err_cnt;
`endif

  imm_encode_gen dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef IMMENC_STATS_EN
    ,
    .stat_inst_cnt(stat_inst_cnt),
    .stat_err_cnt(stat_err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  int   got_lat;
  logic got_mid_rr;

  function automatic logic [31:0] f_i(logic [31:0] imm,
      logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd,
      logic [6:0] opc);
    return ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) |
      (32'(f3) << 12) | (32'(rd) << 7) | 32'(opc);
  endfunction

  // Expected word sequence {word, last, err} from the encoding rules.
  function automatic void ref_model(logic li, logic [4:0] fmt,
      logic [6:0] opc, logic [2:0] f3, logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    longint s;
    logic [31:0] w, hi, lui;
    logic e;
    s = longint'($signed(imm));
    exp_q.delete();
    if (li) begin
      hi  = (imm + 32'h800) >> 12;
      lui = (hi << 12) | (32'(rd) << 7) | 32'h37;
      if (s >= -2048 && s < 2048)
        exp_q.push_back({f_i(imm, 5'd0, 3'd0, rd, 7'h13), 2'b10});
      else if ((imm & 32'hFFF) == 0)
        exp_q.push_back({lui, 2'b10});
      else begin
        exp_q.push_back({lui, 2'b00});
        exp_q.push_back({f_i(imm, rd, 3'd0, rd, 7'h13), 2'b10});
      end
      return;
    end
    case (fmt)
      5'b00001: begin
        w = (imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'(opc);
        e = (imm & 32'hFFF) != 0;
      end
      5'b00010: begin
        w = (((imm >> 20) & 1) << 31) |
            (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 1) << 20) |
            (((imm >> 12) & 32'hFF) << 12) |
            (32'(rd) << 7) | 32'(opc);
        e = s < -1048576 || s > 1048575 || imm[0];
      end
      5'b00100: begin
        w = f_i(imm, rs1, f3, rd, opc);
        e = s < -2048 || s > 2047;
      end
      5'b01000: begin
        w = (((imm >> 12) & 1) << 31) |
            (((imm >> 5) & 32'h3F) << 25) |
            (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8) |
            (((imm >> 11) & 1) << 7) | 32'(opc);
        e = s < -4096 || s > 4095 || imm[0];
      end
      5'b10000: begin
        w = (((imm >> 5) & 32'h7F) << 25) |
            (32'(rs2) << 20) | (32'(rs1) << 15) |
            (32'(f3) << 12) | ((imm & 32'h1F) << 7) |
            32'(opc);
        e = s < -2048 || s > 2047;
      end
      default: begin
        w = 32'h00000013;
        e = 1'b1;
      end
    endcase
    exp_q.push_back({w, 1'b1, e});
  endfunction

  task automatic set_req(logic li, logic [4:0] fmt,
      logic [6:0] opc, logic [2:0] f3, logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm);
    bus.req_li     = li;
    bus.req_fmt    = fmt;
    bus.req_opcode = opc;
    bus.req_funct3 = f3;
    bus.req_rd     = rd;
    bus.req_rs1    = rs1;
    bus.req_rs2    = rs2;
    bus.req_imm    = imm;
  endtask

  // Drive one request (entered at a negedge) and collect its words.
  task automatic issue(logic li, logic [4:0] fmt,
      logic [6:0] opc, logic [2:0] f3, logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm,
      output bit to);
    int n;
    to = 1'b0;
    got_q.delete();
    got_lat = 0;
    got_mid_rr = 1'b1;
    bus.inst_ready = 1'b1;
    set_req(li, fmt, opc, f3, rd, rs1, rs2, imm);
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      to = 1'b1;
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (bus.inst_valid) begin
        if (got_q.size() == 0) got_lat = c;
        got_q.push_back({bus.inst, bus.inst_last, bus.inst_err});
        if (!bus.inst_last) got_mid_rr = bus.req_ready;
        else break;
      end
    end
    if (got_q.size() == 0) to = 1'b1;
    else if (!got_q[got_q.size()-1][1]) to = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.inst_ready = 1'b0;
    set_req(1'b0, 5'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.inst_valid, bus.inst_last, bus.inst_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000",
        {bus.inst_valid, bus.inst_last, bus.inst_err});
    end
    checks++;
    if (bus.inst !== 32'd0) begin
      errors++;
      $display("FAIL reset_inst got %h want 0", bus.inst);
    end
`ifdef IMMENC_STATS_EN
    checks++;
    if (stat_inst_cnt !== 0 || stat_err_cnt !== 0) begin
      errors++;
      $display("FAIL reset_stats got %0d/%0d want 0/0",
        stat_inst_cnt, stat_err_cnt);
    end
`endif
    rst = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready got %b want 1", bus.req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_i_fmt();
    bit to;
    issue(1'b0, 5'b00100, 7'h13, 3'd0, 5'd5, 5'd0, 5'd0,
      32'hFFFFFFFF, to);
    checks++;
    if (to || got_q.size() != 1) begin
      errors++;
      $display("FAIL i_count got %0d words to=%0d want 1",
        got_q.size(), to);
    end else begin
      checks++;
      if (got_q[0] !== {32'hFFF00293, 2'b10}) begin
        errors++;
        $display("FAIL i_word got %h want fff00293/10", got_q[0]);
      end
      checks++;
      if (got_lat != 1) begin
        errors++;
        $display("FAIL i_latency got %0d want 1", got_lat);
      end
    end
  endtask

  task automatic test_b_fmt();
    bit to;
    issue(1'b0, 5'b01000, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2,
      32'd8, to);
    checks++;
    if (to || got_q.size() != 1 ||
        got_q[0] !== {32'h00208463, 2'b10}) begin
      errors++;
      $display("FAIL b_even got n=%0d %h want 00208463/10",
        got_q.size(), got_q.size() ? got_q[0] : 34'd0);
    end
    issue(1'b0, 5'b01000, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2,
      32'd9, to);
    checks++;
    if (to || got_q.size() != 1 || got_q[0][0] !== 1'b1) begin
      errors++;
      $display("FAIL b_odd_err got n=%0d %h want err=1",
        got_q.size(), got_q.size() ? got_q[0] : 34'd0);
    end
  endtask

  task automatic test_li();
    bit to;
    issue(1'b1, 5'd0, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0,
      32'h12345FFF, to);
    checks++;
    if (to || got_q.size() != 2) begin
      errors++;
      $display("FAIL li2_count got %0d want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {32'h12346537, 2'b00} ||
          got_q[1] !== {32'hFFF50513, 2'b10}) begin
        errors++;
        $display("FAIL li2_words got %h %h want 12346537/00 fff50513/10",
          got_q[0], got_q[1]);
      end
      checks++;
      if (got_mid_rr !== 1'b0) begin
        errors++;
        $display("FAIL li2_req_ready got %b want 0", got_mid_rr);
      end
    end
    issue(1'b1, 5'd0, 7'd0, 3'd0, 5'd1, 5'd0, 5'd0,
      32'h00001000, to);
    checks++;
    if (to || got_q.size() != 1 ||
        got_q[0] !== {32'h000010B7, 2'b10}) begin
      errors++;
      $display("FAIL li_lui got n=%0d %h want 000010b7/10",
        got_q.size(), got_q.size() ? got_q[0] : 34'd0);
    end
    issue(1'b1, 5'd0, 7'd0, 3'd0, 5'd3, 5'd0, 5'd0,
      -32'sd5, to);
    checks++;
    if (to || got_q.size() != 1 ||
        got_q[0] !== {32'hFFB00193, 2'b10}) begin
      errors++;
      $display("FAIL li_addi got n=%0d %h want ffb00193/10",
        got_q.size(), got_q.size() ? got_q[0] : 34'd0);
    end
  endtask

  task automatic test_bad_fmt();
    bit to;
    logic [4:0] bad [2];
    bad[0] = 5'b00110;
    bad[1] = 5'b00000;
    for (int k = 0; k < 2; k++) begin
      issue(1'b0, bad[k], 7'h33, 3'd1, 5'd4, 5'd5, 5'd6,
        32'd4, to);
      checks++;
      if (to || got_q.size() != 1 ||
          got_q[0] !== {32'h00000013, 2'b11}) begin
        errors++;
        $display("FAIL bad_fmt %b got n=%0d %h want 00000013/11",
          bad[k], got_q.size(), got_q.size() ? got_q[0] : 34'd0);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w, want;
    ref_model(1'b0, 5'b00100, 7'h13, 3'd0, 5'd9, 5'd7, 5'd0,
      -32'sd100);
    want = exp_q[0][33:2];
    bus.inst_ready = 1'b0;
    set_req(1'b0, 5'b00100, 7'h13, 3'd0, 5'd9, 5'd7, 5'd0,
      -32'sd100);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    w = bus.inst;
    checks++;
    if (bus.inst_valid !== 1'b1 || w !== want) begin
      errors++;
      $display("FAIL bp_first got v=%b %h want v=1 %h",
        bus.inst_valid, w, want);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.inst !== w || bus.inst_valid !== 1'b1 ||
          bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got %h v=%b rr=%b want %h v=1 rr=0",
          bus.inst, bus.inst_valid, bus.req_ready, w);
      end
    end
    bus.inst_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got v=%b want 0", bus.inst_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [4];
    logic [31:0] imm;
    logic [4:0]  fmt;
    bus.inst_ready = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst !== want[k-1]) begin
          errors++;
          $display("FAIL b2b_word%0d got v=%b %h want v=1 %h",
            k - 1, bus.inst_valid, bus.inst, want[k-1]);
        end
      end
      if (k < 4) begin
        imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        fmt = (k % 2) ? 5'b10000 : 5'b00100;
        ref_model(1'b0, fmt, 7'h23, 3'd2, 5'(k + 1), 5'd2,
          5'd3, imm);
        want[k] = exp_q[0][33:2];
        set_req(1'b0, fmt, 7'h23, 3'd2, 5'(k + 1), 5'd2, 5'd3, imm);
        bus.req_valid = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready%0d got %b want 1", k, bus.req_ready);
        end
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got v=%b want 0", bus.inst_valid);
    end
  endtask

  task automatic test_mid_reset();
    bus.inst_ready = 1'b1;
    set_req(1'b1, 5'd0, 7'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.inst !== 32'h12346537 || bus.inst_last !== 1'b0) begin
      errors++;
      $display("FAIL mr_first got %h last=%b want 12346537 last=0",
        bus.inst, bus.inst_last);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.inst_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.inst !== 32'd0) begin
      errors++;
      $display("FAIL mr_drop got v=%b %h want v=0 0",
        bus.inst_valid, bus.inst);
    end
    bus.inst_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL mr_no_second got v=%b %h want v=0",
          bus.inst_valid, bus.inst);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    logic li;
    logic [4:0] fmt, rd, rs1, rs2;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [31:0] imm;
    for (int n = 0; n < 200; n++) begin
      li  = ($urandom_range(0, 3) == 0);
      fmt = ($urandom_range(0, 5) == 0) ? 5'($urandom)
                                        : 5'(1 << $urandom_range(0, 4));
      rd  = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      opc = 7'($urandom);
      f3  = 3'($urandom);
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 16383)) - 32'd8192;
        1: imm = $urandom & 32'hFFFFF000;
        2: imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        default: imm = $urandom;
      endcase
      ref_model(li, fmt, opc, f3, rd, rs1, rs2, imm);
      issue(li, fmt, opc, f3, rd, rs1, rs2, imm, to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rnd%0d_count got %0d want %0d li=%b fmt=%b imm=%h",
          n, got_q.size(), exp_q.size(), li, fmt, imm);
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rnd%0d_w%0d got %h want %h li=%b fmt=%b imm=%h",
              n, i, got_q[i], exp_q[i], li, fmt, imm);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_i_fmt();
    test_b_fmt();
    test_li();
    test_bad_fmt();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
